// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue stage.
package fetch_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int INSTR_BYTES = 4;

  // One fetch-queue slot: instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN_DEF-1:0] ps;
    logic [XLEN_DEF-1:0] buyruk;
  } fq_entry_t;

  // Bits needed for a counter that must be able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head entry is read straight out of
// the storage registers so decode never sees a combinational path from the
// cache response.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t,
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic   [PW-1:0] rd_ptr;
  logic   [PW-1:0] wr_ptr;
  logic            pop_ok;
  logic            push_ok;

  // Guards keep the occupancy counter honest even if a caller misbehaves.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Pipelined instruction fetch: issues in-order cache requests under a credit
// scheme that reserves a queue slot for every live response, buffers returned
// instructions with their PCs, and discards responses made stale by redirects.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int             XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PS = '0,
  parameter int             FQ_DEPTH = 4,
  parameter int             MAX_OUT  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            bellek_istek_o,
  output logic [XLEN-1:0] bellek_ps_o,
  input  logic            bellek_kabul_i,
  input  logic            bellek_gecerli_i,
  input  logic [XLEN-1:0] bellek_deger_i,
  input  logic            coz_bos_i,
  output logic [XLEN-1:0] coz_buyruk_o,
  output logic            coz_buyruk_gecerli_o,
  output logic [XLEN-1:0] coz_ps_o,
  input  logic [XLEN-1:0] yurut_ps_i,
  input  logic            yurut_ps_gecerli_i
);

  localparam int CW = cnt_width(FQ_DEPTH);
  localparam int OW = cnt_width(MAX_OUT);
  localparam int SW = CW + OW + 1;

  typedef struct packed {
    logic [XLEN-1:0] ps;
    logic [XLEN-1:0] buyruk;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_ps;
  logic [XLEN-1:0] target;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   credit;
  logic            redirect;
  logic            fire;
  logic            rsp;
  logic            rsp_live;
  logic            pop;
  entry_t          head;
  entry_t          push_data;
  logic            unused_align;

  assign redirect     = yurut_ps_gecerli_i;
  assign target       = {yurut_ps_i[XLEN-1:2], 2'b00};
  assign unused_align = ^yurut_ps_i[1:0];

  // Queue slots already spoken for: stored entries plus responses still live.
  assign credit = SW'(cnt) + SW'(outstanding) - SW'(drop_cnt);

  assign bellek_istek_o = rst_i && !redirect
                       && (outstanding < OW'(MAX_OUT))
                       && (credit < SW'(FQ_DEPTH));
  assign bellek_ps_o    = pc;
  assign fire           = bellek_istek_o && bellek_kabul_i;

  // Responses with nothing outstanding are spurious and ignored.
  assign rsp      = bellek_gecerli_i && (outstanding != '0);
  assign rsp_live = rsp && (drop_cnt == '0) && !redirect;

  assign coz_buyruk_gecerli_o = (cnt != '0) && !redirect;
  assign pop                  = coz_buyruk_gecerli_o && coz_bos_i;
  assign coz_buyruk_o         = head.buyruk;
  assign coz_ps_o             = head.ps;

  assign push_data = '{ps: rsp_ps, buyruk: bellek_deger_i};

  // Request PC and the PC of the oldest live request (tag for the next kept
  // response); both jump to the redirect target since every older request
  // becomes dead at that point.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc     <= RESET_PS;
      rsp_ps <= RESET_PS;
    end else if (redirect) begin
      pc     <= target;
      rsp_ps <= target;
    end else begin
      if (fire)     pc     <= pc + XLEN'(INSTR_BYTES);
      if (rsp_live) rsp_ps <= rsp_ps + XLEN'(INSTR_BYTES);
    end
  end

  // Outstanding and to-be-dropped response counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      outstanding <= outstanding - OW'(rsp);
      drop_cnt    <= outstanding - OW'(rsp);
    end else begin
      outstanding <= outstanding + OW'(fire) - OW'(rsp);
      if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .push      (rsp_live),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (cnt)
  );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomised bench for fetch_queue_stage against a queue-based reference model.
module tb_fetch_queue_stage;

  localparam int          FQ_DEPTH = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PS = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        bellek_istek_o;
  logic [31:0] bellek_ps_o;
  logic        bellek_kabul_i = 1'b0;
  logic        bellek_gecerli_i = 1'b0;
  logic [31:0] bellek_deger_i = '0;
  logic        coz_bos_i = 1'b0;
  logic [31:0] coz_buyruk_o;
  logic        coz_buyruk_gecerli_o;
  logic [31:0] coz_ps_o;
  logic [31:0] yurut_ps_i = '0;
  logic        yurut_ps_gecerli_i = 1'b0;

  fetch_queue_stage #(
    .XLEN     (32),
    .RESET_PS (RESET_PS),
    .FQ_DEPTH (FQ_DEPTH),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .bellek_istek_o       (bellek_istek_o),
    .bellek_ps_o          (bellek_ps_o),
    .bellek_kabul_i       (bellek_kabul_i),
    .bellek_gecerli_i     (bellek_gecerli_i),
    .bellek_deger_i       (bellek_deger_i),
    .coz_bos_i            (coz_bos_i),
    .coz_buyruk_o         (coz_buyruk_o),
    .coz_buyruk_gecerli_o (coz_buyruk_gecerli_o),
    .coz_ps_o             (coz_ps_o),
    .yurut_ps_i           (yurut_ps_i),
    .yurut_ps_gecerli_i   (yurut_ps_gecerli_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] ps; bit live; } req_t;
  typedef struct { logic [31:0] ps; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] data; int ready; } crsp_t;

  req_t        pend[$];
  ent_t        fq[$];
  crsp_t       cache[$];
  logic [31:0] m_pc;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          p_kabul, p_bos, p_redir, p_rsp, lat_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].live) n++;
    return n;
  endfunction

  function automatic bit exp_istek();
    return rst_i && !yurut_ps_gecerli_i && (pend.size() < MAX_OUT)
           && (fq.size() + live_cnt() < FQ_DEPTH);
  endfunction

  task automatic model_reset();
    pend.delete();
    fq.delete();
    cache.delete();
    m_pc = RESET_PS;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return 32'hFFB8FF13;
      2:       return 32'hFFFFFFF4;
      default: return 32'd696;
    endcase
  endfunction

  task automatic drive_inputs();
    bellek_kabul_i     = ($urandom % 100) < p_kabul;
    coz_bos_i          = ($urandom % 100) < p_bos;
    yurut_ps_gecerli_i = ($urandom % 100) < p_redir;
    yurut_ps_i         = pick_target();
    bellek_deger_i     = $urandom;
    if (cache.size() > 0) begin
      bellek_gecerli_i = (cache[0].ready <= cyc) && (($urandom % 100) < p_rsp);
      if (bellek_gecerli_i) bellek_deger_i = cache[0].data;
    end else begin
      // occasional spurious strobe with nothing outstanding
      bellek_gecerli_i = ($urandom % 100) < 3;
    end
  endtask

  task automatic step();
    bit   e_ist, e_val, fire;
    ent_t hd;
    req_t r;
    @(negedge clk_i);
    e_ist = exp_istek();
    e_val = (fq.size() > 0) && !yurut_ps_gecerli_i;
    check("istek", bellek_istek_o, e_ist);
    check("req_ps", bellek_ps_o, m_pc);
    check("valid", coz_buyruk_gecerli_o, e_val);
    if (e_val) begin
      hd = fq[0];
      check("buyruk", coz_buyruk_o, hd.ins);
      check("coz_ps", coz_ps_o, hd.ps);
    end
    fire = e_ist && bellek_kabul_i;
    @(posedge clk_i);
    cyc++;
    if (bellek_gecerli_i && cache.size() > 0) void'(cache.pop_front());
    if (fire) cache.push_back('{data: $urandom, ready: cyc + $urandom_range(0, lat_max)});
    if (yurut_ps_gecerli_i) begin
      if (bellek_gecerli_i && pend.size() > 0) void'(pend.pop_front());
      foreach (pend[i]) pend[i].live = 1'b0;
      fq.delete();
      m_pc = {yurut_ps_i[31:2], 2'b00};
    end else begin
      if (fq.size() > 0 && coz_bos_i) void'(fq.pop_front());
      if (bellek_gecerli_i && pend.size() > 0) begin
        r = pend.pop_front();
        if (r.live) fq.push_back('{ps: r.ps, ins: bellek_deger_i});
      end
      if (fire) begin
        pend.push_back('{ps: m_pc, live: 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    drive_inputs();
  endtask

  task automatic run(input int n, input int pk, input int pb, input int pr,
                     input int prs, input int lat);
    p_kabul = pk; p_bos = pb; p_redir = pr; p_rsp = prs; lat_max = lat;
    drive_inputs();
    repeat (n) step();
  endtask

  task automatic reset_midstream();
    #2 rst_i = 1'b0;
    #1;
    check("rst_istek", bellek_istek_o, 1'b0);
    check("rst_valid", coz_buyruk_gecerli_o, 1'b0);
    check("rst_buyruk", coz_buyruk_o, 32'h0);
    check("rst_coz_ps", coz_ps_o, 32'h0);
    check("rst_req_ps", bellek_ps_o, RESET_PS);
    model_reset();
    bellek_gecerli_i   = 1'b0;
    yurut_ps_gecerli_i = 1'b0;
    bellek_kabul_i     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("init_istek", bellek_istek_o, 1'b0);
    check("init_valid", coz_buyruk_gecerli_o, 1'b0);
    check("init_buyruk", coz_buyruk_o, 32'h0);
    check("init_coz_ps", coz_ps_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    run(3, 0, 100, 0, 100, 0);        // cache never accepts
    run(20, 100, 100, 0, 100, 0);     // streaming, latency 1
    run(12, 100, 0, 0, 100, 0);       // decode stalled: queue fills
    run(10, 100, 100, 0, 100, 0);     // drain
    run(400, 70, 60, 6, 70, 2);       // mixed random with redirects
    run(6, 100, 0, 0, 60, 1);         // build up state, then reset
    reset_midstream();
    run(400, 80, 50, 10, 60, 3);
    run(200, 100, 100, 25, 100, 0);   // frequent / back-to-back redirects
    run(8, 100, 0, 0, 50, 1);
    reset_midstream();
    run(100, 60, 70, 5, 80, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
